// File: rtl/draw_cmd_arbiter_pkg.sv
// Shared definitions for the draw command arbiter: FSM encoding and command field widths.
package draw_cmd_arbiter_pkg;

    localparam int X_W  = 9;
    localparam int Y_W  = 8;
    localparam int C_W  = 3;
    localparam int WD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_ACK       = 2'd3
    } arb_state_t;

endpackage

// File: rtl/draw_rr_picker.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping modulo NUM_CLIENTS.
module draw_rr_picker #(
    parameter int NUM_CLIENTS = 4,
    parameter int GW          = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [GW-1:0]          rr_ptr,
    output logic [GW-1:0]          winner,
    output logic                   any_req
);

    logic [GW-1:0] idx;

    // Scan rr_ptr+1 .. rr_ptr+N so the last winner is looked at last.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            idx = GW'((int'(rr_ptr) + i) % NUM_CLIENTS);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_cmd_arbiter.sv
// Round-robin arbiter sharing one square-draw engine between NUM_CLIENTS requesters.
// Handshake: client holds req until a 1-cycle ack; engine takes a 1-cycle eng_start and answers with a 1-cycle eng_done.
module draw_cmd_arbiter
    import draw_cmd_arbiter_pkg::*;
#(
    parameter  int NUM_CLIENTS = 4,
    parameter  int TIMEOUT     = 255,
    localparam int GW          = $clog2(NUM_CLIENTS)
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [NUM_CLIENTS-1:0]      req,
    input  logic [X_W*NUM_CLIENTS-1:0]  cmd_x,
    input  logic [Y_W*NUM_CLIENTS-1:0]  cmd_y,
    input  logic [C_W*NUM_CLIENTS-1:0]  cmd_colour,
    output logic [NUM_CLIENTS-1:0]      ack,
    output logic                        eng_start,
    output logic [X_W-1:0]              eng_x,
    output logic [Y_W-1:0]              eng_y,
    output logic [C_W-1:0]              eng_colour,
    input  logic                        eng_done,
    output logic                        busy,
    output logic [GW-1:0]               grant_id,
    output logic                        timeout_err,
    output arb_state_t                  dbg_state
);

    arb_state_t    state;
    arb_state_t    next_state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] winner;
    logic          any_req;
    logic [WD_W-1:0] watchdog;
    logic          wd_expired;

    draw_rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .GW          (GW)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign wd_expired = (watchdog == WD_W'(TIMEOUT - 1));
    assign dbg_state  = state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A done arriving together with watchdog expiry counts as a normal finish.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (any_req) next_state = ST_ISSUE;
            ST_ISSUE:     next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: if (eng_done || wd_expired) next_state = ST_ACK;
            ST_ACK:       next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ack       = '0;
        eng_start = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_ISSUE: eng_start = 1'b1;
            ST_ACK:   ack[grant_id] = 1'b1;
            default:  ;
        endcase
    end

    // Command latch, fairness pointer, watchdog and sticky error.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            grant_id    <= '0;
            eng_x       <= '0;
            eng_y       <= '0;
            eng_colour  <= '0;
            rr_ptr      <= GW'(NUM_CLIENTS - 1);
            watchdog    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_id   <= winner;
                        eng_x      <= cmd_x[int'(winner)*X_W +: X_W];
                        eng_y      <= cmd_y[int'(winner)*Y_W +: Y_W];
                        eng_colour <= cmd_colour[int'(winner)*C_W +: C_W];
                    end
                end
                ST_ISSUE: begin
                    watchdog <= '0;
                end
                ST_WAIT_DONE: begin
                    if (!eng_done) begin
                        if (wd_expired) begin
                            timeout_err <= 1'b1;
                        end else begin
                            watchdog <= watchdog + 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    rr_ptr <= grant_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_cmd_arbiter.sv
// Directed bench for draw_cmd_arbiter: table of single draws plus hand sequences for timeout, spurious done and reset.
module tb_draw_cmd_arbiter;
    import draw_cmd_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int GW = 2;

    logic               clock;
    logic               resetn;
    logic [N-1:0]       req;
    logic [X_W*N-1:0]   cmd_x;
    logic [Y_W*N-1:0]   cmd_y;
    logic [C_W*N-1:0]   cmd_colour;
    logic [N-1:0]       ack;
    logic               eng_start;
    logic [X_W-1:0]     eng_x;
    logic [Y_W-1:0]     eng_y;
    logic [C_W-1:0]     eng_colour;
    logic               eng_done;
    logic               busy;
    logic [GW-1:0]      grant_id;
    logic               timeout_err;
    arb_state_t         dbg_state;

    int checks   = 0;
    int failures = 0;

    draw_cmd_arbiter #(
        .NUM_CLIENTS (N),
        .TIMEOUT     (255)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req         (req),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_colour  (cmd_colour),
        .ack         (ack),
        .eng_start   (eng_start),
        .eng_x       (eng_x),
        .eng_y       (eng_y),
        .eng_colour  (eng_colour),
        .eng_done    (eng_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Client i commands; scramble flips them to prove the latch ignores late changes.
    task automatic set_cmds(input bit scramble);
        logic [X_W*N-1:0] x;
        logic [Y_W*N-1:0] y;
        logic [C_W*N-1:0] c;
        x = {9'd511, 9'd100, 9'd17, 9'd300};
        y = {8'd255, 8'd50, 8'd9, 8'd200};
        c = {3'd7, 3'd5, 3'd2, 3'd1};
        cmd_x      = scramble ? ~x : x;
        cmd_y      = scramble ? ~y : y;
        cmd_colour = scramble ? ~c : c;
    endtask

    typedef struct {
        logic [N-1:0]   req;
        int             delay;
        logic [GW-1:0]  exp_grant;
        logic [X_W-1:0] exp_x;
        logic [Y_W-1:0] exp_y;
        logic [C_W-1:0] exp_c;
        logic [N-1:0]   exp_ack;
    } vec_t;

    vec_t vecs[10];

    // One full draw starting from IDLE: grant, latched command, done after delay cycles, ack.
    task automatic run_vec(input int i, input vec_t v);
        req = v.req;
        tick();
        check($sformatf("v%0d_start", i), 32'(eng_start), 32'd1);
        check($sformatf("v%0d_grant", i), 32'(grant_id), 32'(v.exp_grant));
        check($sformatf("v%0d_x", i), 32'(eng_x), 32'(v.exp_x));
        check($sformatf("v%0d_y", i), 32'(eng_y), 32'(v.exp_y));
        check($sformatf("v%0d_colour", i), 32'(eng_colour), 32'(v.exp_c));
        req = '0;
        set_cmds(1'b1);
        tick();
        check($sformatf("v%0d_start_pulse", i), 32'(eng_start), 32'd0);
        check($sformatf("v%0d_wait_state", i), 32'(dbg_state), 32'(ST_WAIT_DONE));
        repeat (v.delay) tick();
        check($sformatf("v%0d_no_early_ack", i), 32'(ack), 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check($sformatf("v%0d_ack", i), 32'(ack), 32'(v.exp_ack));
        check($sformatf("v%0d_x_held", i), 32'(eng_x), 32'(v.exp_x));
        set_cmds(1'b0);
        tick();
        check($sformatf("v%0d_ack_pulse", i), 32'(ack), 32'd0);
        check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    endtask

    initial begin
        int n;

        vecs[0] = '{4'b1111, 3,  2'd0, 9'd300, 8'd200, 3'd1, 4'b0001};
        vecs[1] = '{4'b1111, 1,  2'd1, 9'd17,  8'd9,   3'd2, 4'b0010};
        vecs[2] = '{4'b1111, 0,  2'd2, 9'd100, 8'd50,  3'd5, 4'b0100};
        vecs[3] = '{4'b1111, 5,  2'd3, 9'd511, 8'd255, 3'd7, 4'b1000};
        vecs[4] = '{4'b1111, 2,  2'd0, 9'd300, 8'd200, 3'd1, 4'b0001};
        vecs[5] = '{4'b0100, 52, 2'd2, 9'd100, 8'd50,  3'd5, 4'b0100};
        vecs[6] = '{4'b0010, 4,  2'd1, 9'd17,  8'd9,   3'd2, 4'b0010};
        vecs[7] = '{4'b1010, 1,  2'd3, 9'd511, 8'd255, 3'd7, 4'b1000};
        vecs[8] = '{4'b1010, 1,  2'd1, 9'd17,  8'd9,   3'd2, 4'b0010};
        vecs[9] = '{4'b0001, 0,  2'd0, 9'd300, 8'd200, 3'd1, 4'b0001};

        resetn   = 1'b0;
        req      = '0;
        eng_done = 1'b0;
        set_cmds(1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_start", 32'(eng_start), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_x", 32'(eng_x), 32'd0);
        check("rst_y", 32'(eng_y), 32'd0);
        check("rst_colour", 32'(eng_colour), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Spurious done in IDLE and in ISSUE must be ignored.
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("spur_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("spur_idle_ack", 32'(ack), 32'd0);
        req = 4'b0001;
        tick();
        eng_done = 1'b1;
        check("spur_issue_start", 32'(eng_start), 32'd1);
        tick();
        eng_done = 1'b0;
        req = '0;
        check("spur_issue_state", 32'(dbg_state), 32'(ST_WAIT_DONE));
        check("spur_issue_ack", 32'(ack), 32'd0);
        tick();
        check("spur_still_wait", 32'(dbg_state), 32'(ST_WAIT_DONE));
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("spur_final_ack", 32'(ack), 32'b0001);
        tick();

        // Engine never finishes: abort after 255 cycles in WAIT_DONE.
        req = 4'b0010;
        tick();
        check("to_grant", 32'(grant_id), 32'd1);
        req = '0;
        tick();
        check("to_terr_before", 32'(timeout_err), 32'd0);
        n = 0;
        while (dbg_state == ST_WAIT_DONE && n < 400) begin
            tick();
            n++;
        end
        check("to_wait_cycles", 32'(n), 32'd255);
        check("to_ack", 32'(ack), 32'b0010);
        check("to_terr", 32'(timeout_err), 32'd1);
        tick();
        check("to_idle", 32'(busy), 32'd0);
        req = 4'b1000;
        tick();
        check("to_next_grant", 32'(grant_id), 32'd3);
        req = '0;
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("to_next_ack", 32'(ack), 32'b1000);
        check("to_terr_sticky", 32'(timeout_err), 32'd1);
        tick();

        // Reset mid-draw: outputs clear at once, request served again after release.
        req = 4'b0100;
        tick();
        check("rm_grant", 32'(grant_id), 32'd2);
        tick();
        repeat (10) tick();
        resetn = 1'b0;
        #1;
        check("rm_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_ack", 32'(ack), 32'd0);
        check("rm_x", 32'(eng_x), 32'd0);
        check("rm_terr", 32'(timeout_err), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("rm_hold_ack", 32'(ack), 32'd0);
        resetn = 1'b1;
        tick();
        check("rm_restart", 32'(eng_start), 32'd1);
        check("rm_regrant", 32'(grant_id), 32'd2);
        check("rm_x_relatch", 32'(eng_x), 32'd100);
        req = '0;
        tick();

        // Done arrives in the same cycle the watchdog would expire.
        repeat (254) tick();
        check("tie_still_wait", 32'(dbg_state), 32'(ST_WAIT_DONE));
        check("tie_terr_before", 32'(timeout_err), 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("tie_ack", 32'(ack), 32'b0100);
        check("tie_terr", 32'(timeout_err), 32'd0);
        tick();
        check("tie_idle", 32'(busy), 32'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
